// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Loadable instruction memory + PC, one instruction per cycle over
//            a valid/ready handshake. Define IFETCH_HALT_EN to stop at ENDOP.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int                ADDR_W = 8,
    parameter int                INS_W  = 8,
    parameter logic [INS_W-1:0]  ENDOP  = INS_W'(28)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [INS_W-1:0]  prog_data,
    input  logic              start,
    input  logic              ins_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [INS_W-1:0]  ins,
    output logic              ins_valid,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              halted
);

    localparam int         c_DEPTH = 1 << ADDR_W;
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_HALT  = 2'd2;

`ifdef IFETCH_HALT_EN
    localparam bit c_HALT_EN = 1'b1;
`else
    localparam bit c_HALT_EN = 1'b0;
`endif

    logic [INS_W-1:0]  r_mem [0:c_DEPTH-1];
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [INS_W-1:0]  r_ins;
    logic [ADDR_W-1:0] r_ins_pc;
    logic              r_valid;

    logic              w_accept;
    logic              w_advance;
    logic [ADDR_W-1:0] w_src;
    logic [INS_W-1:0]  w_word;
    logic              w_is_end;
    logic              w_prog_ok;

    assign w_accept  = r_valid && ins_ready;
    assign w_advance = (r_state == c_FETCH) && (!r_valid || ins_ready);
    assign w_src     = (w_accept && jump_en) ? jump_addr : r_pc;
    assign w_word    = r_mem[w_src];
    assign w_is_end  = c_HALT_EN && (w_word == ENDOP);
    // Writes are only safe while no fetch can race them.
    assign w_prog_ok = prog_we &&
                       ((r_state == c_IDLE) || (c_HALT_EN && (r_state == c_HALT)));

    always_ff @(posedge clk) begin
        if (w_prog_ok) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_pc     <= '0;
            r_ins    <= '0;
            r_ins_pc <= '0;
            r_valid  <= 1'b0;
        end else if (start) begin
            // Restart from any state; a pending instruction is dropped.
            r_state <= c_FETCH;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (w_advance) begin
                        r_ins    <= w_word;
                        r_ins_pc <= w_src;
                        r_valid  <= 1'b1;
                        r_pc     <= w_src + 1'b1;
                        if (w_is_end) begin
                            r_state <= c_HALT;
                        end
                    end
                end
                c_HALT: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IFETCH_HALT_EN
    logic r_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (start) begin
            r_halted <= 1'b0;
        end else if ((r_state == c_HALT) && w_accept) begin
            r_halted <= 1'b1;
        end
    end

    assign halted = r_halted;
`else
    assign halted = 1'b0;
`endif

    assign ins       = r_ins;
    assign ins_valid = r_valid;
    assign ins_pc    = r_ins_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Directed self-checking bench for instr_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic       clk;
    logic       rst;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic       start;
    logic       ins_ready;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic [7:0] ins;
    logic       ins_valid;
    logic [7:0] ins_pc;
    logic       halted;

    int n_vec;
    int n_miss;

    instr_fetch #(
        .ADDR_W (8),
        .INS_W  (8),
        .ENDOP  (8'd28)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .ins_ready (ins_ready),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .ins       (ins),
        .ins_valid (ins_valid),
        .ins_pc    (ins_pc),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic expect_ins(input string tag, input logic [7:0] d, input logic [7:0] pc);
        check({tag, ".valid"}, {31'd0, ins_valid}, 32'd1);
        check({tag, ".ins"},   {24'd0, ins},       {24'd0, d});
        check({tag, ".pc"},    {24'd0, ins_pc},    {24'd0, pc});
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start.valid0", {31'd0, ins_valid}, 32'd0);
        check("start.halted0", {31'd0, halted}, 32'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        ins_ready = 1'b0;
        jump_en   = 1'b0;
        jump_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst.ins",    {24'd0, ins},    32'd0);
        check("rst.valid",  {31'd0, ins_valid}, 32'd0);
        check("rst.pc",     {24'd0, ins_pc}, 32'd0);
        check("rst.halted", {31'd0, halted}, 32'd0);

        load(8'd0,   8'd5);
        load(8'd1,   8'd6);
        load(8'd2,   8'd7);
        load(8'd3,   8'd28);
        load(8'd4,   8'h44);
        load(8'd9,   8'd28);
        load(8'd10,  8'h3A);
        load(8'd254, 8'hFE);
        load(8'd255, 8'd28);
        check("idle.novalid", {31'd0, ins_valid}, 32'd0);

        // Straight-line fetch up to ENDOP
        do_start();
        ins_ready = 1'b1;
        tick(); expect_ins("seq0", 8'd5,  8'd0);
        tick(); expect_ins("seq1", 8'd6,  8'd1);
        tick(); expect_ins("seq2", 8'd7,  8'd2);
        tick(); expect_ins("seq3", 8'd28, 8'd3);
        tick();
`ifdef IFETCH_HALT_EN
        check("halt.valid",  {31'd0, ins_valid}, 32'd0);
        check("halt.halted", {31'd0, halted},    32'd1);
        tick();
        check("halt.noread", {24'd0, ins_pc},    32'd3);
        check("halt.stay",   {31'd0, halted},    32'd1);
`else
        expect_ins("seq4", 8'h44, 8'd4);
        check("nohalt.halted", {31'd0, halted}, 32'd0);
`endif

        // Backpressure with an ignored program write during FETCH
        do_start();
        ins_ready = 1'b0;
        tick(); expect_ins("bp.first", 8'd5, 8'd0);
        prog_we   = 1'b1;
        prog_addr = 8'd1;
        prog_data = 8'h99;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_ins("bp.hold", 8'd5, 8'd0);
        end
        prog_we   = 1'b0;
        ins_ready = 1'b1;
        tick(); expect_ins("bp.next", 8'd6, 8'd1);
        tick(); expect_ins("bp.next2", 8'd7, 8'd2);

        // Jump: ignored without ready, taken with ready
        do_start();
        ins_ready = 1'b0;
        tick(); expect_ins("jmp.first", 8'd5, 8'd0);
        jump_en   = 1'b1;
        jump_addr = 8'd9;
        tick(); expect_ins("jmp.noready", 8'd5, 8'd0);
        ins_ready = 1'b1;
        tick(); expect_ins("jmp.taken", 8'd28, 8'd9);
`ifdef IFETCH_HALT_EN
        jump_addr = 8'd0;
        tick();
        check("jmp.halt.valid",  {31'd0, ins_valid}, 32'd0);
        check("jmp.halt.halted", {31'd0, halted},    32'd1);
        check("jmp.halt.pc",     {24'd0, ins_pc},    32'd9);
        jump_en = 1'b0;
`else
        jump_en = 1'b0;
        tick(); expect_ins("jmp.after", 8'h3A, 8'd10);
`endif

        // Asynchronous reset mid-stream
        do_start();
        ins_ready = 1'b1;
        tick(); expect_ins("ar.0", 8'd5, 8'd0);
        tick(); expect_ins("ar.1", 8'd6, 8'd1);
        tick(); expect_ins("ar.2", 8'd7, 8'd2);
        rst = 1'b1;
        #1;
        check("ar.ins",    {24'd0, ins},       32'd0);
        check("ar.valid",  {31'd0, ins_valid}, 32'd0);
        check("ar.pc",     {24'd0, ins_pc},    32'd0);
        check("ar.halted", {31'd0, halted},    32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("ar.idle", {31'd0, ins_valid}, 32'd0);
        do_start();
        tick(); expect_ins("ar.re0", 8'd5, 8'd0);
        tick(); expect_ins("ar.re1", 8'd6, 8'd1);

        // Jump near top of memory
        jump_en   = 1'b1;
        jump_addr = 8'd254;
        tick(); expect_ins("wrap.254", 8'hFE, 8'd254);
        jump_en = 1'b0;
        tick(); expect_ins("wrap.255", 8'd28, 8'd255);
        tick();
`ifdef IFETCH_HALT_EN
        check("wrap.halted", {31'd0, halted},    32'd1);
        check("wrap.valid",  {31'd0, ins_valid}, 32'd0);
        load(8'd1, 8'h99);
`else
        expect_ins("wrap.0", 8'd5, 8'd0);
        check("wrap.halted0", {31'd0, halted}, 32'd0);
        tick(); expect_ins("wrap.1", 8'd6, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load(8'd1, 8'h99);
`endif

        // Write accepted outside FETCH is visible after restart
        do_start();
        ins_ready = 1'b1;
        tick(); expect_ins("pw.0", 8'd5,  8'd0);
        tick(); expect_ins("pw.1", 8'h99, 8'd1);
        tick(); expect_ins("pw.2", 8'd7,  8'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
